// File: rtl/cmp_pkg.sv
// Shared types and encodings for the sequential magnitude comparator.
//
// Contents:
//   state_e  - controller states (idle, walking slices, result presentation)
//   RES_*    - one-hot compare result encoding {gt, eq, lt}
//   cmp_res  - helper that builds a RES_* code from gt/lt flags
package cmp_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmp  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [2:0] RES_GT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  // gt and lt are never both set by callers; neither set means equal.
  function automatic logic [2:0] cmp_res(input logic gt, input logic lt);
    logic [2:0] res;
    res = RES_EQ;
    if (gt) begin
      res = RES_GT;
    end else if (lt) begin
      res = RES_LT;
    end
    return res;
  endfunction

endpackage

// File: rtl/cmp2_slice.sv
// Purely combinational 2-bit magnitude compare slice.
//
// Ports:
//   a_i   [1:0] - operand A slice
//   b_i   [1:0] - operand B slice
//   res_o [2:0] - one-hot {gt, eq, lt} in RES_* encoding
module cmp2_slice
  import cmp_pkg::*;
(
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [2:0] res_o
);

  always_comb begin
    res_o = cmp_res(a_i > b_i, a_i < b_i);
  end

endmodule

// File: rtl/comparator_seq_ctrl.sv
// Sequential WIDTH-bit magnitude comparator. Operands are captured on an accepted start and
// walked MSB-first through a single 2-bit compare slice, one slice per clock. The first unequal
// slice decides the outcome; if no slice differs the operands are equal.
//
// Build option: define COMPARE_EARLY_EXIT_EN to leave the walk as soon as the first unequal
// slice is found. Results are identical either way; only the latency changes.
//
// Ports:
//   clk          - rising-edge clock
//   rst_n        - asynchronous active-low reset
//   start        - request, sampled only while idle
//   a, b [W-1:0] - operands, captured when start is accepted
//   busy         - high whenever the controller is not idle
//   done         - one-cycle pulse, result valid in the same cycle
//   result [2:0] - {a>b, a==b, a<b}; cleared on acceptance, held after done
module comparator_seq_ctrl
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [2:0]       result
);

  localparam int unsigned NSLICE = WIDTH / 2;
  localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

`ifdef COMPARE_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("comparator_seq_ctrl: WIDTH must be even and >= 2");
  end

  state_e           state_q;
  logic [IdxW-1:0]  idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       pend_q;
  logic             decided_q;
  logic [2:0]       result_q;
  logic             done_q;

  logic [1:0]       sl_a;
  logic [1:0]       sl_b;
  logic [2:0]       slice_res;
  logic [2:0]       pend_d;
  logic             decided_d;
  logic [2:0]       final_res;
  logic             last_step;

  // Select the slice at idx; shifting keeps the mux width-agnostic.
  always_comb begin
    sl_a = 2'(a_q >> {idx_q, 1'b0});
    sl_b = 2'(b_q >> {idx_q, 1'b0});
  end

  cmp2_slice u_slice (
    .a_i   (sl_a),
    .b_i   (sl_b),
    .res_o (slice_res)
  );

  // Only the first unequal slice (MSB-first) may set the pending result.
  always_comb begin
    pend_d    = pend_q;
    decided_d = decided_q;
    if (!decided_q && (slice_res != RES_EQ)) begin
      pend_d    = slice_res;
      decided_d = 1'b1;
    end
    final_res = decided_d ? pend_d : RES_EQ;
    last_step = (idx_q == '0) || (EarlyExit && decided_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      pend_q    <= RES_NONE;
      decided_q <= 1'b0;
      result_q  <= RES_NONE;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            result_q  <= RES_NONE;
            pend_q    <= RES_NONE;
            decided_q <= 1'b0;
            idx_q     <= IdxW'(NSLICE - 1);
            state_q   <= StCmp;
          end
        end
        StCmp: begin
          pend_q    <= pend_d;
          decided_q <= decided_d;
          if (last_step) begin
            result_q <= final_res;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end else begin
            idx_q <= idx_q - IdxW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_comparator_seq_ctrl.sv
module tb_comparator_seq_ctrl;

  localparam int W = 8;
  localparam int NS = W / 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [2:0]   result;

  comparator_seq_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far (index of the next edge).
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned acc;
    logic [2:0]  res;
    int unsigned lat;
  } exp_t;

  exp_t        q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned idle_at = 0;
  logic [2:0]  last_res = 3'b000;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  function automatic logic [2:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x > y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  // Cycles from acceptance edge to the done cycle.
  function automatic int unsigned ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef COMPARE_EARLY_EXIT_EN
    for (int s = NS - 1; s >= 0; s--) begin
      if (2'(x >> (2 * s)) != 2'(y >> (2 * s))) return NS - s + 1;
    end
`endif
    if (x == y) return NS + 1;
    return NS + 1;
  endfunction

  // Drive one cycle of stimulus; the request is accepted by the next edge only if the
  // reference says the block is idle by then.
  task automatic tick(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    @(posedge clk);
    #1;
    start = st;
    a = av;
    b = bv;
    if (st && (cyc >= idle_at)) begin
      e.acc = cyc;
      e.res = ref_res(av, bv);
      e.lat = ref_lat(av, bv);
      q.push_back(e);
      idle_at = cyc + e.lat + 1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() > 0; i++) tick(1'b0, a, b);
    tick(1'b0, a, b);
    tick(1'b0, a, b);
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    int unsigned j;
    if (rst_n && mon_en) begin
      if (q.size() > 0 && cyc > q[0].acc) begin
        j = cyc - q[0].acc;
        check("busy_inflight", 3'(busy), 3'd1);
        if (j == 1) check("result_clear", result, 3'b000);
        if (j < q[0].lat) begin
          check("done_early", 3'(done), 3'd0);
        end else begin
          check("done_pulse", 3'(done), 3'd1);
          check("result", result, q[0].res);
          last_res = q[0].res;
          void'(q.pop_front());
        end
      end else begin
        check("busy_idle", 3'(busy), 3'd0);
        check("done_idle", 3'(done), 3'd0);
        check("result_hold", result, last_res);
      end
    end
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    // Reset state
    #12;
    check("rst_busy", 3'(busy), 3'd0);
    check("rst_done", 3'(done), 3'd0);
    check("rst_result", result, 3'b000);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_at = cyc;
    mon_en = 1'b1;

    // Directed cases
    tick(1'b1, 8'hA5, 8'hA5);
    tick(1'b0, 8'h00, 8'h00);
    drain();
    tick(1'b1, 8'h80, 8'h7F);
    tick(1'b0, 8'h00, 8'h00);
    drain();
    tick(1'b1, 8'h02, 8'h03);
    tick(1'b0, 8'h00, 8'h00);
    drain();

    // Request during CMP is ignored
    tick(1'b1, 8'h10, 8'h20);
    for (int i = 0; i < 3; i++) tick(1'b1, 8'hFF, 8'h00);
    tick(1'b0, 8'h00, 8'h00);
    drain();

    // Asynchronous reset in the second CMP cycle
    tick(1'b1, 8'hC3, 8'h3C);
    tick(1'b0, 8'h00, 8'h00);
    tick(1'b0, 8'h00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", 3'(busy), 3'd0);
    check("async_done", 3'(done), 3'd0);
    check("async_result", result, 3'b000);
    q.delete();
    last_res = 3'b000;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle_at = cyc;
    tick(1'b1, 8'h01, 8'h00);
    tick(1'b0, 8'h00, 8'h00);
    drain();

    // Start held high: back-to-back operations
    for (int i = 0; i < 20; i++) tick(1'b1, 8'h55, 8'hAA);
    tick(1'b0, 8'h00, 8'h00);
    drain();

    // Randomized traffic, including requests while busy and operand changes in flight
    for (int i = 0; i < 150; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 4) == 0) rb = ra;
      if ($urandom_range(0, 3) == 0) rb = ra ^ W'(1 << $urandom_range(0, W - 1));
      tick($urandom_range(0, 2) != 0, ra, rb);
    end
    tick(1'b0, 8'h00, 8'h00);
    drain();

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d responses never arrived, expected 0", q.size());
    end
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
